// File: rtl/game_input_conditioner_if.sv
// rtl/game_input_conditioner_if.sv - raw button inputs and clean command outputs of game_input_conditioner
interface game_input_conditioner_if;
    logic start;
    logic left_raw;
    logic right_raw;
    logic throw_raw;
    logic left_step;
    logic right_step;
    logic throw_pulse;
    logic left_level;
    logic right_level;
    logic throw_level;

    modport master (
        output start, left_raw, right_raw, throw_raw,
        input  left_step, right_step, throw_pulse, left_level, right_level, throw_level
    );

    modport slave (
        input  start, left_raw, right_raw, throw_raw,
        output left_step, right_step, throw_pulse, left_level, right_level, throw_level
    );
endinterface

// File: rtl/game_input_conditioner.sv
// rtl/game_input_conditioner.sv - sync, debounce and step/throw pulse generation; INPUT_REPEAT_EN builds auto-repeat
module game_input_conditioner #(
    parameter int DEB_CNT      = 2,
    parameter int REPEAT_DELAY = 6,
    parameter int REPEAT_RATE  = 3
) (
    input  logic                     buttonclk,
    input  logic                     reset,
    game_input_conditioner_if.slave  bus
);
    if (DEB_CNT < 1 || DEB_CNT > 15 || REPEAT_DELAY < 2 || REPEAT_DELAY > 63 ||
        REPEAT_RATE < 1 || REPEAT_RATE > 63) begin : g_param_check
        $error("game_input_conditioner: parameter out of legal range");
    end

    localparam logic [3:0] DEB_LAST = 4'(DEB_CNT - 1);

`ifdef INPUT_REPEAT_EN
    localparam logic [5:0] DELAY_LAST = 6'(REPEAT_DELAY - 1);
    localparam logic [5:0] RATE_LAST  = 6'(REPEAT_RATE - 1);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT, ST_BLOCKED} dir_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_BLOCKED} dir_state_t;
`endif

    // Bit order everywhere: 0 = left, 1 = right, 2 = throw
    logic [2:0] w_raw;
    logic [2:0] r_s1;
    logic [2:0] r_s2;
    logic [2:0] r_h1;
    logic [2:0] r_h2;
    logic [2:0] r_lock;
    logic [3:0] r_deb_cnt [3];
    logic [2:0] r_level;
    logic [2:0] r_level_d;
    logic [2:0] w_rise;
    logic       w_conflict;
    logic [1:0] r_step;
    logic       r_throw_pulse;

    assign w_raw      = {bus.throw_raw, bus.right_raw, bus.left_raw};
    assign w_rise     = r_level & ~r_level_d;
    assign w_conflict = r_level[0] & r_level[1];

    always_ff @(posedge buttonclk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Free-running copy so a button held across reset can be recognised and locked out
    always_ff @(posedge buttonclk) begin
        r_h1 <= w_raw;
        r_h2 <= r_h1;
    end

    always_ff @(posedge buttonclk) begin
        if (reset) begin
            r_lock <= r_h2;
        end else begin
            r_lock <= r_lock & r_h2;
        end
    end

    always_ff @(posedge buttonclk) begin
        if (reset) begin
            r_level   <= '0;
            r_level_d <= '0;
            for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_level_d <= r_level;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_level[i]   <= ~r_level[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 4'd1;
                end
            end
        end
    end

    for (genvar d = 0; d < 2; d++) begin : g_dir
        dir_state_t r_state;
        dir_state_t w_state_nxt;
        logic       w_step_nxt;
`ifdef INPUT_REPEAT_EN
        logic [5:0] r_cnt;
        logic [5:0] w_cnt_nxt;
`endif

        always_ff @(posedge buttonclk) begin
            if (reset) begin
                r_state   <= ST_IDLE;
                r_step[d] <= 1'b0;
`ifdef INPUT_REPEAT_EN
                r_cnt     <= '0;
`endif
            end else begin
                r_state   <= w_state_nxt;
                r_step[d] <= w_step_nxt;
`ifdef INPUT_REPEAT_EN
                r_cnt     <= w_cnt_nxt;
`endif
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_step_nxt  = 1'b0;
`ifdef INPUT_REPEAT_EN
            w_cnt_nxt   = r_cnt;
`endif
            if (!bus.start) begin
                w_state_nxt = ST_IDLE;
`ifdef INPUT_REPEAT_EN
                w_cnt_nxt   = '0;
`endif
            end else if (w_conflict) begin
                w_state_nxt = ST_BLOCKED;
`ifdef INPUT_REPEAT_EN
                w_cnt_nxt   = '0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise[d] && !r_lock[d]) begin
                            w_step_nxt  = 1'b1;
`ifdef INPUT_REPEAT_EN
                            w_state_nxt = ST_WAIT;
                            w_cnt_nxt   = '0;
`else
                            w_state_nxt = ST_HELD;
`endif
                        end
                    end
`ifdef INPUT_REPEAT_EN
                    ST_WAIT: begin
                        if (!r_level[d]) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == DELAY_LAST) begin
                            w_step_nxt  = 1'b1;
                            w_state_nxt = ST_REPEAT;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = r_cnt + 6'd1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!r_level[d]) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == RATE_LAST) begin
                            w_step_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt   = r_cnt + 6'd1;
                        end
                    end
                    ST_BLOCKED: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = r_level[d] ? ST_WAIT : ST_IDLE;
                    end
`else
                    ST_HELD: begin
                        if (!r_level[d]) w_state_nxt = ST_IDLE;
                    end
                    ST_BLOCKED: begin
                        w_state_nxt = r_level[d] ? ST_HELD : ST_IDLE;
                    end
`endif
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge buttonclk) begin
        if (reset) begin
            r_throw_pulse <= 1'b0;
        end else begin
            r_throw_pulse <= bus.start && w_rise[2] && !r_lock[2];
        end
    end

    assign bus.left_step   = r_step[0];
    assign bus.right_step  = r_step[1];
    assign bus.throw_pulse = r_throw_pulse;
    assign bus.left_level  = r_level[0];
    assign bus.right_level = r_level[1];
    assign bus.throw_level = r_level[2];
endmodule

// File: tb/tb_game_input_conditioner.sv
// tb/tb_game_input_conditioner.sv - directed vector bench for game_input_conditioner
module tb_game_input_conditioner;
    logic buttonclk = 1'b0;
    logic reset     = 1'b1;

    game_input_conditioner_if bus ();

    game_input_conditioner #(
        .DEB_CNT      (2),
        .REPEAT_DELAY (6),
        .REPEAT_RATE  (3)
    ) dut (
        .buttonclk (buttonclk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 buttonclk = ~buttonclk;

    int total = 0;
    int bad   = 0;
    int cnt_l, cnt_r, cnt_t;

`ifdef INPUT_REPEAT_EN
    localparam bit REP = 1'b1;
    localparam int HOLD30_L = 8;
    localparam int REL30_L  = 1;
`else
    localparam bit REP = 1'b0;
    localparam int HOLD30_L = 1;
    localparam int REL30_L  = 0;
`endif

    typedef struct {
        bit start, l, r, t;
        int n;
        int el, er, et;
        bit ll, rl, tl;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic setin(input bit s, input bit l, input bit r, input bit t);
        bus.start     = s;
        bus.left_raw  = l;
        bus.right_raw = r;
        bus.throw_raw = t;
    endtask

    task automatic clr_counts;
        cnt_l = 0;
        cnt_r = 0;
        cnt_t = 0;
    endtask

    task automatic tick;
        @(posedge buttonclk);
        #1;
        cnt_l += int'(bus.left_step);
        cnt_r += int'(bus.right_step);
        cnt_t += int'(bus.throw_pulse);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " left_step"},   int'(bus.left_step),   0);
        check({tag, " right_step"},  int'(bus.right_step),  0);
        check({tag, " throw_pulse"}, int'(bus.throw_pulse), 0);
        check({tag, " left_level"},  int'(bus.left_level),  0);
        check({tag, " right_level"}, int'(bus.right_level), 0);
        check({tag, " throw_level"}, int'(bus.throw_level), 0);
    endtask

    // Pulses must be exclusive and never two cycles wide
    logic p_l, p_r, p_t;
    always @(negedge buttonclk) begin
        if (!reset) begin
            check("mon step exclusive", int'(bus.left_step && bus.right_step), 0);
            check("mon left width",  int'(p_l && bus.left_step), 0);
            check("mon right width", int'(p_r && bus.right_step), 0);
            check("mon throw width", int'(p_t && bus.throw_pulse), 0);
        end
        p_l = bus.left_step;
        p_r = bus.right_step;
        p_t = bus.throw_pulse;
    end

    initial begin
        //          start l  r  t  n   el        er et ll rl tl
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  0,        0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8,  0,        0, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10, 0,        0, 1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8,  0,        0, 0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10, 0,        0, 0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10, 0,        0, 0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8,  0,        0, 0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8,  0,        0, 1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8,  0,        0, 0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 30, HOLD30_L, 0, 0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, REL30_L,  0, 0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 0,        0, 0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 0,        0, 0, 1'b1, 1'b0, 1'b0};

        p_l = 1'b0;
        p_r = 1'b0;
        p_t = 1'b0;
        clr_counts();
        setin(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");

        // Debounce latency: raw seen at edge 0, level at edge 3, step at edge 4
        reset = 1'b0;
        setin(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("lat k%0d left_level", k), int'(bus.left_level), int'(k >= 3));
            check($sformatf("lat k%0d left_step", k),  int'(bus.left_step),  int'(k == 4));
            check($sformatf("lat k%0d right_step", k), int'(bus.right_step), 0);
            check($sformatf("lat k%0d throw", k),      int'(bus.throw_pulse), 0);
        end
        setin(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();

        for (int i = 0; i < 13; i++) begin
            setin(tbl[i].start, tbl[i].l, tbl[i].r, tbl[i].t);
            clr_counts();
            repeat (tbl[i].n) tick();
            check($sformatf("vec%0d left_step count", i),   cnt_l, tbl[i].el);
            check($sformatf("vec%0d right_step count", i),  cnt_r, tbl[i].er);
            check($sformatf("vec%0d throw_pulse count", i), cnt_t, tbl[i].et);
            check($sformatf("vec%0d left_level", i),  int'(bus.left_level),  int'(tbl[i].ll));
            check($sformatf("vec%0d right_level", i), int'(bus.right_level), int'(tbl[i].rl));
            check($sformatf("vec%0d throw_level", i), int'(bus.throw_level), int'(tbl[i].tl));
        end
        setin(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();

        // Auto-repeat; the pulse at 25 is inside the release debounce window
        setin(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 36; k++) begin
            tick();
            check($sformatf("rep k%0d right_step", k), int'(bus.right_step),
                  int'(k == 4 || (REP && k >= 10 && k <= 25 && (k - 10) % 3 == 0)));
            check($sformatf("rep k%0d left_step", k), int'(bus.left_step), 0);
            if (k == 22) setin(1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Conflict while left is waiting for its first repeat
        setin(1'b1, 1'b1, 1'b0, 1'b0);
        clr_counts();
        repeat (5) tick();
        check("conf first left_step", cnt_l, 1);
        setin(1'b1, 1'b1, 1'b1, 1'b0);
        clr_counts();
        repeat (15) tick();
        check("conf held left_step count",  cnt_l, 0);
        check("conf held right_step count", cnt_r, 0);
        check("conf left_level",  int'(bus.left_level),  1);
        check("conf right_level", int'(bus.right_level), 1);
        setin(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("resume k%0d left_step", k),  int'(bus.left_step),  int'(REP && k == 10));
            check($sformatf("resume k%0d right_step", k), int'(bus.right_step), 0);
        end
        setin(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();

        // Reset in the middle of a right-hand hold
        setin(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (14) tick();
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        clr_counts();
        repeat (20) tick();
        check("after reset held right_step count", cnt_r, 0);
        check("after reset right_level", int'(bus.right_level), 1);
        setin(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();
        setin(1'b1, 1'b0, 1'b1, 1'b0);
        clr_counts();
        repeat (6) tick();
        check("repress right_step count", cnt_r, 1);
        setin(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_input_conditioner.md
Name: game_input_conditioner

Overview:
- Front-end stage between the board push-buttons/switches and the brick-breaker game core. Runs on buttonclk.
- Synchronises and debounces the raw left/right/throw inputs.
- Converts them into clean one-cycle command pulses. left/right get hold-to-auto-repeat; throw is one-shot.
- The game core consumes only these pulses, so one press moves the paddle exactly one column.

Parameters:
- DEB_CNT, 2, consecutive stable synchronised samples needed to change a debounced level (legal 1..15)
- REPEAT_DELAY, 6, buttonclk cycles from the first left/right pulse to the first auto-repeat pulse (legal 2..63)
- REPEAT_RATE, 3, buttonclk cycles between successive auto-repeat pulses (legal 1..63)

Ports:
- buttonclk  input  1  game tick clock
- reset  input  1  synchronous, active-high
- start  input  1  game enable; pulse outputs are gated by it
- left_raw  input  1  raw asynchronous button, active-high
- right_raw  input  1  raw asynchronous button, active-high
- throw_raw  input  1  raw asynchronous button, active-high
- left_step  output  1  one-cycle pulse: move paddle left one column
- right_step  output  1  one-cycle pulse: move paddle right one column
- throw_pulse  output  1  one-cycle pulse: launch ball
- left_level  output  1  debounced level of left
- right_level  output  1  debounced level of right
- throw_level  output  1  debounced level of throw

Behaviour:
- Interface: reset is synchronous, active-high; clock is buttonclk. All state updates on posedge buttonclk.
- Reset values:
  - All outputs 0.
  - Synchroniser flops 0, debounce counters 0, repeat counters 0.
  - Both direction FSMs in IDLE; throw edge register 0.
  - Reset asserted mid-hold aborts any repeat sequence. After reset releases with a button still held, that button produces no pulse until it is released and pressed again (debounced level re-qualifies 0 -> 1).
- Synchroniser: two flops per input, sync = s2.
- Debounce, per input:
  - Counter width 4.
  - If sync == level, counter clears to 0.
  - Otherwise counter increments. When it already equals DEB_CNT-1, level toggles and counter clears.
  - Latency: raw stable from the edge-0 sample, so *_level changes at edge DEB_CNT+1 (edge 3 for the default).
  - Glitches shorter than DEB_CNT synchronised samples never reach *_level.
- Conflict rule: left_level && right_level means both steps are suppressed. Both direction FSMs go to BLOCKED and their counters clear.
- Direction FSM (identical for left and right), states IDLE, WAIT, REPEAT, BLOCKED:
  - IDLE: on a rising edge of the level with no conflict and start=1, pulse step for one cycle, go to WAIT, counter = 0.
  - WAIT: counter increments each cycle. When counter reaches REPEAT_DELAY-1, pulse, go to REPEAT, counter = 0.
  - REPEAT: counter increments. When counter reaches REPEAT_RATE-1, pulse and counter = 0.
  - WAIT/REPEAT: level falling returns to IDLE with no pulse that cycle.
  - BLOCKED: when conflict ends with this level still 1, go to WAIT with counter 0 and no immediate pulse. If this level is 0, go to IDLE.
- Throw: throw_pulse = rising edge of throw_level && start. No repeat.
- Start gating:
  - start=0 forces all step/throw pulses to 0 and holds the FSMs in IDLE.
  - Debounce continues, so *_level stays valid.
  - A button already held when start rises produces no pulse.
- Pulses are registered outputs, never wider than one cycle. left_step and right_step are never high together.

Optional Feature:
- Macro: INPUT_REPEAT_EN.
- Defined: auto-repeat as above.
- Undefined:
  - WAIT and REPEAT are not built, and the FSM collapses to IDLE/HELD/BLOCKED.
  - Exactly one pulse per qualified press; nothing more until release.
  - REPEAT_DELAY and REPEAT_RATE are ignored.
  - BLOCKED exits to HELD (no pulse) instead of WAIT.

Test Plan:
- Reset plus debounce latency: after reset, raise left_raw at edge 0 and hold, start=1. Required: left_level=1 after edge 3; left_step high exactly one cycle, registered on the rising edge of left_level; no other pulses.
- Glitch rejection: throw_raw high for one cycle only, DEB_CNT=2. Required: throw_level stays 0 and no throw_pulse. Then hold throw_raw high for 10 cycles: exactly one throw_pulse.
- Auto-repeat (macro defined): hold right_raw for 20 cycles after qualification. Required: pulse at qualification, next after 6 cycles, then every 3 cycles (offsets 0, 6, 9, 12, 15, 18). Release: no further pulses.
- Conflict: hold left, then right also qualifies while left's FSM is in WAIT. Required: zero step pulses while both are held. Release right: left resumes with the first pulse 6 cycles later, no immediate pulse.
- Start gating plus mid-operation reset: hold throw with start=0, then raise start. Required: no throw_pulse until release and re-press. Assert reset for one cycle during right auto-repeat: all outputs 0 the next cycle, and no right_step until re-press.
- Macro undefined: hold left 30 cycles. Required: exactly one left_step.
